iir_cascade_engine: RTL and testbench
=====================================

// Module: iir_cascade_engine
// PURPOSE
//   Time-multiplexed N-stage biquad IIR cascade engine. Reads per-stage Q2.14
//   coefficients from the combinational coefficient table by driving stage_index.
//   Runs each accepted sample through all stages on one shared multiplier.
//   Sits between the sample source (valid/ready) and the downstream sink.
// PARAMETERS
//   N_STAGES  6   biquad sections; stage_index counts 0..N_STAGES-1
//   DW        16  signed sample width, Q1.15
//   CW        16  signed coefficient width
//   CFRAC     14  coefficient fraction bits (0x4000 = 1.0)
//   ACCW      40  signed accumulator width
//   SIW       3   stage_index width
// PORTS
//   clk          in   1    single clock; all state changes on rising edge
//   rst_n        in   1    synchronous reset, active-low
//   flush        in   1    sync clear: abort current sample, zero all history
//   in_valid     in   1    input sample valid
//   in_ready     out  1    engine can accept a sample (IDLE only)
//   in_data      in   DW   input sample
//   stage_index  out  SIW  coefficient-table select, registered
//   b0,b1,b2     in   CW   numerator coeffs for stage_index, same cycle
//   a1,a2        in   CW   denominator coeffs for stage_index, same cycle
//   out_valid    out  1    filtered sample available
//   out_ready    in   1    sink accepts out_data
//   out_data     out  DW   filtered sample, held while out_valid=1
//   sat_flag     out  1    sticky: any stage output saturated since reset/flush
// BEHAVIOUR
//   Reset (rst_n=0 at edge): state=IDLE, in_ready=1, out_valid=0, out_data=0,
//     stage_index=0, sat_flag=0, accumulator and all x1/x2/y1/y2 history = 0.
//   Priority: rst_n > flush > normal. flush: same as reset except it is a
//     separate pin; takes effect at the edge it is high, in any state.
//   FSM: IDLE -> MAC -> WB -> (MAC next stage | DONE) -> IDLE.
//     IDLE: in_ready=1; in_valid&in_ready latches in_data as x, stage=0, phase=0.
//     MAC: 5 cycles, phase 0..4 accumulates, acc cleared at phase 0:
//       p0 +b0*x, p1 +b1*x1[s], p2 +b2*x2[s], p3 -a1*y1[s], p4 -a2*y2[s].
//     WB (1 cycle): y = sat(round(acc)); x2[s]<=x1[s]; x1[s]<=x; y2[s]<=y1[s];
//       y1[s]<=y; x<=y; if s==N_STAGES-1 -> DONE (out_data<=y) else s<=s+1 -> MAC.
//     DONE: out_valid=1, out_data stable; on out_ready -> IDLE. in_ready=0.
//   stage_index = s during MAC/WB, 0 in IDLE/DONE; coefficients sampled
//     combinationally in the same cycle (table has no latency).
//   Latency: 6 cycles/stage; handshake in cycle t -> out_valid high in cycle
//     t+1+6*N_STAGES (t+37 at default). Throughput 1 sample per >=38 cycles.
//   Arithmetic: product DW x CW signed = 32b (Q3.29), sign-extend to ACCW.
//     round: acc + (1<<(CFRAC-1)), arithmetic >>> CFRAC; saturate to
//     [-2^(DW-1), 2^(DW-1)-1]; on clip sat_flag<=1. Accumulator never wraps
//     for DW=CW=16 (5 products < 2^35).
//   Boundaries: in_valid while busy ignored (in_ready=0); out_ready while
//     out_valid=0 ignored; flush in DONE drops out_valid next cycle, sample lost;
//     rst_n/flush mid-MAC discard partial acc and leave no history update.
// STRUCTURE
//   Package iir_pkg: DW, CW, CFRAC, ACCW, N_STAGES, SIW constants; FSM state
//     enum {IDLE,MAC,WB,DONE}; phase enum P_B0..P_A2; round/saturate function.
//   Sub-module iir_mac_unit: signed multiply, add/subtract into ACCW
//     accumulator, clear-on-phase0, round+saturate output with clip flag.
//   History: four N_STAGES x DW register arrays indexed by s.
// TESTING
//   1 Reset: rst_n=0 two cycles -> in_ready=1, out_valid=0, stage_index=0,
//     out_data=0, sat_flag=0.
//   2 Passthrough stub table (b0=0x4000, rest 0): in 0x1234 -> out 0x1234
//     exactly 37 cycles later; stage_index steps 0..5, 6 cycles each.
//   3 Saturation stub (b0=0x7FFF, rest 0): in 0x4000 -> out 0x7FFF,
//     sat_flag=1; in 0x8000 -> out 0x8000.
//   4 Backpressure: out_ready=0 for 10 cycles -> out_valid, out_data stable,
//     in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
//   5 Flush at cycle 15 of a sample -> next cycle in_ready=1, out_valid=0,
//     sat_flag=0; following impulse 0x7FFF matches golden model from zero state.
//   6 Real coefficient table: impulse 0x7FFF then 63 zeros -> 64 outputs
//     bit-exact vs fixed-point golden model; rst_n mid-MAC -> reset state.

Source files
------------

// File: rtl/iir_pkg.sv
// Shared constants, FSM/phase encodings and the round-and-saturate helper
// for the time-multiplexed biquad cascade engine.
package iir_pkg;

    localparam int N_STAGES = 6;
    localparam int DW       = 16;
    localparam int CW       = 16;
    localparam int CFRAC    = 14;
    localparam int ACCW     = 40;
    localparam int SIW      = 3;
    localparam int PW       = DW + CW;

    localparam logic [SIW-1:0] LAST_STAGE = SIW'(N_STAGES - 1);

    localparam logic signed [ACCW-1:0] ACC_HALF = ACCW'(1) <<< (CFRAC - 1);
    localparam logic signed [ACCW-1:0] Y_MAX    = ACCW'((2 ** (DW - 1)) - 1);
    localparam logic signed [ACCW-1:0] Y_MIN    = ACCW'(-(2 ** (DW - 1)));

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        WB,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        P_B0,
        P_B1,
        P_B2,
        P_A1,
        P_A2
    } phase_t;

    typedef struct packed {
        logic signed [DW-1:0] y;
        logic                 clip;
    } sat_t;

    // Round half-up at the coefficient binary point, then clamp to the sample range.
    function automatic sat_t round_sat(input logic signed [ACCW-1:0] acc);
        logic signed [ACCW-1:0] r;
        sat_t                   res;
        r        = (acc + ACC_HALF) >>> CFRAC;
        res.y    = r[DW-1:0];
        res.clip = 1'b0;
        if (r > Y_MAX) begin
            res.y    = Y_MAX[DW-1:0];
            res.clip = 1'b1;
        end else if (r < Y_MIN) begin
            res.y    = Y_MIN[DW-1:0];
            res.clip = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/iir_cascade_engine_mac.sv
// Shared multiply-accumulate datapath: one signed product per cycle, added to
// or subtracted from a wide accumulator; rounded/saturated view of the result.
module iir_mac_unit
    import iir_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 first,
    input  logic                 sub,
    input  logic signed [DW-1:0] sample,
    input  logic signed [CW-1:0] coef,
    output logic signed [DW-1:0] y,
    output logic                 clip
);

    logic signed [PW-1:0]   prod;
    logic signed [ACCW-1:0] term;
    logic signed [ACCW-1:0] base;
    logic signed [ACCW-1:0] acc_d;
    logic signed [ACCW-1:0] acc_q;
    sat_t                   rs;

    // NOTE: every signal written here gets a default before any branch, so no latch is inferred.
    always_comb begin
        prod  = PW'(sample) * PW'(coef);
        term  = ACCW'(prod);
        base  = first ? '0 : acc_q;
        acc_d = acc_q;
        if (en) begin
            acc_d = sub ? (base - term) : (base + term);
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign rs   = round_sat(acc_q);
    assign y    = rs.y;
    assign clip = rs.clip;

endmodule

// File: rtl/iir_cascade_engine.sv
// Biquad cascade engine: each accepted sample walks through N_STAGES sections,
// five MAC phases plus one write-back cycle per section, on one multiplier.
module iir_cascade_engine
    import iir_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_data,
    output logic [SIW-1:0]       stage_index,
    input  logic signed [CW-1:0] b0,
    input  logic signed [CW-1:0] b1,
    input  logic signed [CW-1:0] b2,
    input  logic signed [CW-1:0] a1,
    input  logic signed [CW-1:0] a2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        out_data,
    output logic                 sat_flag
);

    state_t               state_q, state_d;
    phase_t               phase_q, phase_d;
    logic [SIW-1:0]       stage_q, stage_d;
    logic signed [DW-1:0] x_q, x_d;
    logic [DW-1:0]        out_data_q, out_data_d;
    logic                 sat_q, sat_d;

    logic signed [DW-1:0] x1_q [N_STAGES];
    logic signed [DW-1:0] x2_q [N_STAGES];
    logic signed [DW-1:0] y1_q [N_STAGES];
    logic signed [DW-1:0] y2_q [N_STAGES];
    logic signed [DW-1:0] x1_d [N_STAGES];
    logic signed [DW-1:0] x2_d [N_STAGES];
    logic signed [DW-1:0] y1_d [N_STAGES];
    logic signed [DW-1:0] y2_d [N_STAGES];

    logic signed [DW-1:0] mac_sample;
    logic signed [CW-1:0] mac_coef;
    logic                 mac_sub;
    logic signed [DW-1:0] mac_y;
    logic                 mac_clip;

    always_comb begin
        mac_sample = x_q;
        mac_coef   = b0;
        mac_sub    = 1'b0;
        unique case (phase_q)
            P_B1: begin mac_sample = x1_q[stage_q]; mac_coef = b1; end
            P_B2: begin mac_sample = x2_q[stage_q]; mac_coef = b2; end
            P_A1: begin mac_sample = y1_q[stage_q]; mac_coef = a1; mac_sub = 1'b1; end
            P_A2: begin mac_sample = y2_q[stage_q]; mac_coef = a2; mac_sub = 1'b1; end
            default: ;
        endcase
    end

    iir_mac_unit u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (flush),
        .en     (state_q == MAC),
        .first  (phase_q == P_B0),
        .sub    (mac_sub),
        .sample (mac_sample),
        .coef   (mac_coef),
        .y      (mac_y),
        .clip   (mac_clip)
    );

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        stage_d    = stage_q;
        x_d        = x_q;
        out_data_d = out_data_q;
        sat_d      = sat_q;
        x1_d       = x1_q;
        x2_d       = x2_q;
        y1_d       = y1_q;
        y2_d       = y2_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = in_data;
                    stage_d = '0;
                    phase_d = P_B0;
                    state_d = MAC;
                end
            end
            MAC: begin
                if (phase_q == P_A2) begin
                    state_d = WB;
                end else begin
                    phase_d = phase_t'(phase_q + 3'd1);
                end
            end
            WB: begin
                x2_d[stage_q] = x1_q[stage_q];
                x1_d[stage_q] = x_q;
                y2_d[stage_q] = y1_q[stage_q];
                y1_d[stage_q] = mac_y;
                x_d           = mac_y;
                sat_d         = sat_q | mac_clip;
                phase_d       = P_B0;
                if (stage_q == LAST_STAGE) begin
                    // Park the stage select at 0 so the table sees 0 while DONE/IDLE.
                    out_data_d = mac_y;
                    stage_d    = '0;
                    state_d    = DONE;
                end else begin
                    stage_d = stage_q + 1'b1;
                    state_d = MAC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the history arrays are explicitly cleared because reset and flush must restart every section from zero state.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            state_q    <= IDLE;
            phase_q    <= P_B0;
            stage_q    <= '0;
            x_q        <= '0;
            out_data_q <= '0;
            sat_q      <= 1'b0;
            for (int i = 0; i < N_STAGES; i++) begin
                x1_q[i] <= '0;
                x2_q[i] <= '0;
                y1_q[i] <= '0;
                y2_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            stage_q    <= stage_d;
            x_q        <= x_d;
            out_data_q <= out_data_d;
            sat_q      <= sat_d;
            x1_q       <= x1_d;
            x2_q       <= x2_d;
            y1_q       <= y1_d;
            y2_q       <= y2_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign out_data    = out_data_q;
    assign stage_index = stage_q;
    assign sat_flag    = sat_q;

endmodule

// File: tb/tb_iir_cascade_engine.sv
// Scoreboard bench for iir_cascade_engine: a longint golden model predicts each
// output at the input handshake; the monitor pops and compares on output handshake.
module tb_iir_cascade_engine;

    localparam int LAT = 37;

    localparam int REAL_TBL [30] = '{
         1024,  2048,  1024, -20000, 8000,
         2048,     0, -2048, -10000, 6000,
         4096,  4096,     0,  -8192, 2048,
         8192, -4096,  2048,   5000, 4000,
        16384,     0,     0, -16000, 7000,
         3000,  6000,  3000, -12000, 5000
    };

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [2:0]  stage_index;
    logic [15:0] b0, b1, b2, a1, a2;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        sat_flag;

    int tbl_mode = 0;
    int cyc = 0;
    int total_cnt = 0;
    int bad_cnt = 0;

    typedef struct {
        logic [15:0] data;
        int          t_in;
    } sb_entry_t;

    sb_entry_t sb[$];

    longint mx1 [6];
    longint mx2 [6];
    longint my1 [6];
    longint my2 [6];
    bit     msat;

    iir_cascade_engine dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .stage_index (stage_index),
        .b0          (b0),
        .b1          (b1),
        .b2          (b2),
        .a1          (a1),
        .a2          (a2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .sat_flag    (sat_flag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int coef(input int mode, input int s, input int k);
        if (mode == 0) return (k == 0) ? 16384 : 0;
        if (mode == 1) return (k == 0) ? 32767 : 0;
        if (s < 0 || s > 5) return 0;
        return REAL_TBL[s * 5 + k];
    endfunction

    always_comb begin
        b0 = 16'(coef(tbl_mode, int'(stage_index), 0));
        b1 = 16'(coef(tbl_mode, int'(stage_index), 1));
        b2 = 16'(coef(tbl_mode, int'(stage_index), 2));
        a1 = 16'(coef(tbl_mode, int'(stage_index), 3));
        a2 = 16'(coef(tbl_mode, int'(stage_index), 4));
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 6; s++) begin
            mx1[s] = 0; mx2[s] = 0; my1[s] = 0; my2[s] = 0;
        end
        msat = 1'b0;
    endtask

    task automatic model_step(input logic signed [15:0] xin, output logic [15:0] yout);
        longint x, acc, r;
        x = longint'(xin);
        for (int s = 0; s < 6; s++) begin
            acc = longint'(coef(tbl_mode, s, 0)) * x
                + longint'(coef(tbl_mode, s, 1)) * mx1[s]
                + longint'(coef(tbl_mode, s, 2)) * mx2[s]
                - longint'(coef(tbl_mode, s, 3)) * my1[s]
                - longint'(coef(tbl_mode, s, 4)) * my2[s];
            r = (acc + 64'sd8192) >>> 14;
            if (r > 32767) begin r = 32767; msat = 1'b1; end
            if (r < -32768) begin r = -32768; msat = 1'b1; end
            mx2[s] = mx1[s]; mx1[s] = x;
            my2[s] = my1[s]; my1[s] = r;
            x = r;
        end
        yout = 16'(x);
    endtask

    // Entered and left at posedge+1, the point where the bench drives inputs.
    task automatic send(input logic [15:0] d, output logic [15:0] expv);
        sb_entry_t e;
        int waited = 0;
        while (!in_ready && waited < 400) begin
            @(posedge clk); #1;
            waited++;
        end
        check("send_ready", in_ready, 1);
        model_step(d, expv);
        e.data = expv;
        e.t_in = cyc;
        sb.push_back(e);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while ((sb.size() != 0 || !in_ready) && n < 300);
        check("drain_empty", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        sb.delete();
    endtask

    task automatic check_idle_state(input string tag);
        check({tag, "_in_ready"},  in_ready,    1);
        check({tag, "_out_valid"}, out_valid,   0);
        check({tag, "_stage"},     stage_index, 0);
        check({tag, "_out_data"},  out_data,    0);
        check({tag, "_sat"},       sat_flag,    0);
    endtask

    logic ov_prev = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && !ov_prev && sb.size() != 0) begin
                check("latency", cyc - sb[0].t_in, LAT);
            end
            if (out_valid && out_ready) begin
                check("sb_has_entry", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    sb_entry_t e;
                    e = sb.pop_front();
                    check("out_data", out_data, e.data);
                end
            end
        end
        ov_prev = out_valid;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] expv;
        int waited;

        do_reset();
        @(negedge clk);
        check_idle_state("reset");
        @(posedge clk); #1;

        // Passthrough table: exact data, 37-cycle latency, stage walk 0..5.
        tbl_mode = 0;
        send(16'h1234, expv);
        check("pass_model", expv, 16'h1234);
        for (int k = 0; k < 36; k++) begin
            @(negedge clk);
            if (k % 6 == 0 || k % 6 == 5) check("stage_walk", stage_index, k / 6);
        end
        @(posedge clk); #1;
        drain();

        // Saturating table: overflow clamps positive and negative.
        tbl_mode = 1;
        send(16'h4000, expv);
        drain();
        check("sat_pos_val", expv, 16'h7FFF);
        @(negedge clk);
        check("sat_flag_set", sat_flag, msat);
        @(posedge clk); #1;
        send(16'h8000, expv);
        drain();
        check("sat_neg_val", expv, 16'h8000);

        // Backpressure: output held, inputs ignored, release returns to IDLE.
        tbl_mode  = 0;
        out_ready = 1'b0;
        send(16'h0555, expv);
        waited = 0;
        while (!out_valid && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("bp_valid_seen", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            in_valid = (i % 2 == 0);
            in_data  = 16'h7777;
            @(negedge clk);
            check("bp_valid", out_valid, 1);
            check("bp_data",  out_data,  expv);
            check("bp_ready", in_ready,  0);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_rel_ready", in_ready,  1);
        check("bp_rel_valid", out_valid, 0);
        @(posedge clk); #1;
        check("bp_sb_empty", sb.size(), 0);

        // Flush mid-sample on the real table, then an impulse from zero state.
        tbl_mode = 2;
        send(16'h3000, expv);
        drain();
        send(16'h1000, expv);
        repeat (14) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        model_reset();
        sb.delete();
        @(negedge clk);
        check_idle_state("flush");
        @(posedge clk); #1;
        send(16'h7FFF, expv);
        drain();

        // Real table impulse response, 64 outputs from reset state.
        do_reset();
        tbl_mode = 2;
        @(posedge clk); #1;
        for (int i = 0; i < 64; i++) begin
            send((i == 0) ? 16'h7FFF : 16'h0000, expv);
        end
        drain();
        @(negedge clk);
        check("imp_sat_flag", sat_flag, msat);
        @(posedge clk); #1;

        // Reset in the middle of stage 1 MAC.
        send(16'h2000, expv);
        repeat (8) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        sb.delete();
        @(negedge clk);
        check_idle_state("midrst");
        @(posedge clk); #1;
        send(16'h7FFF, expv);
        drain();

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
